// File: rtl/dbg_access_sequencer_if.sv
// Command/response handshake between the serial command decoder (master)
// and the debug access sequencer (slave).
interface dbg_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dbg_access_sequencer.sv
// Sequences one debugger command at a time onto the MCU debug port: halts the
// MCU when needed, issues the access strobe, waits with timeout, returns a response.
//
// state | meaning
// IDLE  | ready for a command, latch op/addr/data/be on req_valid
// HALT  | pause asserted, waiting for mcu_busy to fall (timed)
// ISSUE | one-cycle access strobe
// WAIT  | waiting for mcu_done (timed)
// RST   | one-cycle reset pulse to the MCU
// RESP  | response held until rsp_ready
module dbg_access_sequencer #(
    parameter int TIMEOUT     = 1024,
    parameter bit AUTO_RESUME = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    dbg_access_sequencer_if.slave cmd,
    input  logic [31:0]           pc_i,
    input  logic                  mcu_busy_i,
    input  logic                  mcu_done_i,
    input  logic [31:0]           mcu_rd_data_i,
    input  logic                  mcu_error_i,
    output logic [31:0]           addr_o,
    output logic [31:0]           d_in_o,
    output logic [3:0]            mem_be_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic                  reg_rd_o,
    output logic                  reg_wr_o,
    output logic                  pause_o,
    output logic                  resume_o,
    output logic                  reset_o,
    output logic                  dbg_paused_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RST   = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [2:0] OP_STATUS = 3'd0;
    localparam logic [2:0] OP_MEM_RD = 3'd1;
    localparam logic [2:0] OP_MEM_WR = 3'd2;
    localparam logic [2:0] OP_REG_RD = 3'd3;
    localparam logic [2:0] OP_REG_WR = 3'd4;
    localparam logic [2:0] OP_PAUSE  = 3'd5;
    localparam logic [2:0] OP_RESUME = 3'd6;
    localparam logic [2:0] OP_RESET  = 3'd7;

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;
    logic             implicit_q, implicit_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             resume_q, resume_d;

    logic timed_out;
    logic is_read;
    logic enter_resp;

    assign timed_out = (cnt_q == CNT_LAST);
    assign is_read   = (op_q == OP_MEM_RD) || (op_q == OP_REG_RD);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        implicit_d = implicit_q;
        paused_d   = paused_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        resume_d   = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd.req_valid) begin
                    op_d   = cmd.req_op;
                    addr_d = cmd.req_addr;
                    data_d = cmd.req_data;
                    be_d   = cmd.req_be;
                    case (cmd.req_op)
                        OP_MEM_RD, OP_MEM_WR, OP_REG_RD, OP_REG_WR: begin
                            if (paused_q) begin
                                state_d = ST_ISSUE;
                            end else begin
                                implicit_d = 1'b1;
                                cnt_d      = '0;
                                state_d    = ST_HALT;
                            end
                        end
                        OP_PAUSE: begin
                            cnt_d   = '0;
                            state_d = ST_HALT;
                        end
                        OP_RESUME: begin
                            resume_d   = 1'b1;
                            paused_d   = 1'b0;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b0;
                            state_d    = ST_RESP;
                        end
                        OP_RESET: begin
                            state_d = ST_RST;
                        end
                        default: begin
                            rsp_data_d = pc_i;
                            rsp_err_d  = 1'b0;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end

            ST_HALT: begin
                // A halt that arrives on the last allowed cycle still wins over the timeout.
                if (!mcu_busy_i) begin
                    if (op_q == OP_PAUSE) begin
                        paused_d   = 1'b1;
                        rsp_data_d = pc_i;
                        rsp_err_d  = 1'b0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (timed_out) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (mcu_done_i) begin
                    rsp_data_d = is_read ? mcu_rd_data_i : 32'h0;
                    rsp_err_d  = mcu_error_i;
                    enter_resp = 1'b1;
                end else if (timed_out) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RST: begin
                paused_d   = 1'b0;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                if (cmd.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving HALT/WAIT toward the response releases an implicit halt.
        if (enter_resp) begin
            state_d = ST_RESP;
            if (implicit_q) begin
                resume_d   = AUTO_RESUME;
                implicit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_STATUS;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            implicit_q <= 1'b0;
            paused_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            resume_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            implicit_q <= implicit_d;
            paused_q   <= paused_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            resume_q   <= resume_d;
        end
    end

    assign cmd.req_ready = (state_q == ST_IDLE);
    assign cmd.rsp_valid = (state_q == ST_RESP);
    assign cmd.rsp_data  = rsp_data_q;
    assign cmd.rsp_err   = rsp_err_q;

    assign addr_o   = addr_q;
    assign d_in_o   = data_q;
    assign mem_be_o = be_q;

    assign mem_rd_o = (state_q == ST_ISSUE) && (op_q == OP_MEM_RD);
    assign mem_wr_o = (state_q == ST_ISSUE) && (op_q == OP_MEM_WR);
    assign reg_rd_o = (state_q == ST_ISSUE) && (op_q == OP_REG_RD);
    assign reg_wr_o = (state_q == ST_ISSUE) && (op_q == OP_REG_WR);

    assign pause_o = (state_q == ST_HALT) || paused_q ||
                     (implicit_q && ((state_q == ST_ISSUE) || (state_q == ST_WAIT)));

    assign resume_o     = resume_q;
    assign reset_o      = (state_q == ST_RST);
    assign dbg_paused_o = paused_q;

endmodule

// File: doc/dbg_access_sequencer.md
# dbg_access_sequencer

Sequences debugger commands onto the MCU debug port. Sits between the serial command decoder and the target MCU. Accepts one decoded command at a time and halts the MCU when the access needs it. Issues the register-file or memory strobe, waits for completion with a timeout, and returns one response word. It also auto-resumes the MCU when the halt was only needed for that access.

## Interface
- TIMEOUT, 1024: max cycles spent in HALT or WAIT before aborting with error
- AUTO_RESUME, 1: 1 = resume the MCU after an access that required an implicit halt
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous reset, active low
- req_valid  in  1  command present
- req_ready  out  1  sequencer can accept a command
- req_op  in  3  0 STATUS, 1 MEM_RD, 2 MEM_WR, 3 REG_RD, 4 REG_WR, 5 PAUSE, 6 RESUME, 7 RESET
- req_addr  in  32  memory byte address or register index
- req_data  in  32  write data
- req_be  in  4  memory byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data or PC
- rsp_err  out  1  timeout or MCU error
- pc  in  32  MCU program counter
- mcu_busy  in  1  MCU executing; low when halted at an instruction boundary
- mcu_done  in  1  single-cycle completion of the issued access
- mcu_rd_data  in  32  access read data, valid with mcu_done
- mcu_error  in  1  access fault, valid with mcu_done
- addr, d_in  out  32  registered copy of req_addr and req_data
- mem_be  out  4  registered copy of req_be
- mem_rd, mem_wr, reg_rd, reg_wr  out  1  single-cycle access strobes
- pause  out  1  level; MCU holds while high
- resume, reset  out  1  single-cycle pulses to the MCU
- dbg_paused  out  1  MCU held by an explicit PAUSE

## Operation
- States: IDLE, HALT, ISSUE, WAIT, RST, RESP.
- IDLE: req_ready=1. On req_valid, latch op, addr, data and be.
  - MEM_*/REG_* go to ISSUE if dbg_paused=1; otherwise set the implicit flag and go to HALT.
  - PAUSE goes to HALT.
  - RESUME pulses resume, clears dbg_paused and goes to RESP.
  - RESET goes to RST.
  - STATUS goes to RESP with rsp_data=pc.
- HALT: pause=1. When mcu_busy=0:
  - for PAUSE, set dbg_paused and go to RESP with rsp_data=pc;
  - otherwise go to ISSUE.
- ISSUE: assert exactly one strobe for 1 cycle, then go to WAIT. mcu_done during ISSUE is ignored.
- WAIT: on mcu_done, latch rsp_data (mcu_rd_data for reads, 0 for writes) and rsp_err=mcu_error, then go to RESP.
- RST: reset=1 for 1 cycle, clear dbg_paused, then go to RESP with rsp_data=0.
- RESP: rsp_valid=1 until rsp_ready. Go to IDLE the cycle after rsp_valid&rsp_ready.
  - On RESP entry, if the implicit flag is set and AUTO_RESUME=1: pulse resume once, then clear the flag.
- pause = (state==HALT) | dbg_paused | (implicit flag & state in ISSUE/WAIT).
- Timeout: the counter clears on entry to HALT and to WAIT and increments each cycle there. When count==TIMEOUT-1 without the exit condition:
  - go to RESP with rsp_err=1, rsp_data=0;
  - a PAUSE that times out leaves dbg_paused=0;
  - the implicit-resume rule still applies.

## Timing
- Reset (reset_n=0 at a clock edge): state IDLE. All outputs 0 except req_ready=1. dbg_paused=0 and the implicit flag clear.
- Reset mid-operation: any strobe or pause drops at that edge, no response is produced, and the MCU is released.
- Pre-paused MEM_RD accepted at cycle T:
  - mem_rd at T+1;
  - mcu_done at D ≥ T+2;
  - rsp_valid at D+1.
- Implicit halt adds a minimum of one HALT cycle before ISSUE.
- STATUS, RESUME and RESET: rsp_valid at T+1 (STATUS, RESUME) or T+2 (RESET).
- req_ready=0 in every state but IDLE. Requests are not queued.
- rsp_data and rsp_err stay stable while rsp_valid=1.
- addr, d_in and mem_be hold from acceptance until the next acceptance.

## Test plan
- MEM_WR, addr=0x100, data=0xDEADBEEF, be=0xF, dbg_paused=0, mcu_busy falls 3 cycles later:
  - pause high through WAIT;
  - one mem_wr pulse with addr=0x100;
  - after mcu_done: rsp_valid, rsp_err=0;
  - one resume pulse, then pause low.
- PAUSE with pc=0x2C, then REG_RD idx 5 with mcu_rd_data=0x1234: dbg_paused=1, rsp_data=0x2C; REG_RD gives reg_rd at T+1, rsp_data=0x1234, no resume pulse, pause stays high.
- mcu_busy held high, TIMEOUT=16, MEM_RD: after 16 HALT cycles rsp_valid with rsp_err=1, rsp_data=0, mem_rd never asserted, pause low afterwards.
- MEM_RD with mcu_error=1 on mcu_done: rsp_err=1; a second req_valid during WAIT is not accepted (req_ready=0).
- reset_n low during WAIT: the next cycle has all strobes and pause at 0, rsp_valid=0, req_ready=1; then a RESET op gives a 1-cycle reset pulse and rsp_valid at T+2.
